// File: rtl/reg_arb_pkg.sv
// Shared types and helpers for the register-bank arbiter.
package reg_arb_pkg;

    localparam int DATA_W = 32;
    localparam int MAX_N  = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic logic [MAX_N-1:0] onehot(input logic [2:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          gnt_any
);

    int j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (req[j] && !gnt_any) begin
                gnt_any = 1'b1;
                gnt[j]  = 1'b1;
                gnt_idx = PW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Register bank shared by N requesters: one access per cycle, round-robin
// arbitration, with an optional lock for atomic read-modify-write sequences.
module reg_bank_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int AW       = 3,
    parameter int LOCK_TMO = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        we,
    input  logic [N-1:0]        lock,
    input  logic [N*AW-1:0]     addr,
    input  logic [N*DATA_W-1:0] wdata,
    output logic [N-1:0]        gnt,
    output logic [N-1:0]        rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                locked,
    output logic                state_dbg
);

    // Handshake: req[i] is the valid, gnt[i] the ready; an access is taken on
    // the rising edge where req[i] && gnt[i]. Requesters hold req/we/lock/addr/wdata
    // until granted. Read data returns one cycle later as an rvalid[i] pulse.

    localparam int PW    = $clog2(N);
    localparam int CW    = $clog2(LOCK_TMO + 1);
    localparam int DEPTH = 2 ** AW;

    arb_state_t          state_q, state_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0]   bank [DEPTH];
    logic [N-1:0]        rvalid_q;
    logic [DATA_W-1:0]   rdata_q;

    logic [N-1:0]        rr_gnt;
    logic [PW-1:0]       rr_idx;
    logic                rr_any;

    logic [N-1:0]        gnt_c;
    logic [PW-1:0]       sel_idx;
    logic                sel_any;
    logic [AW-1:0]       sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                sel_we;
    logic                sel_lock;
    logic [MAX_N-1:0]    owner_oh_full;
    logic [N-1:0]        owner_oh;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == PW'(N - 1)) ? '0 : i + PW'(1);
    endfunction

    rr_arbiter #(.N(N), .PW(PW)) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign owner_oh_full = onehot(3'(owner_q));
    assign owner_oh      = owner_oh_full[N-1:0];

    // Grant selection: round-robin when idle, only the owner while locked.
    always_comb begin
        gnt_c   = '0;
        sel_idx = '0;
        sel_any = 1'b0;
        if (state_q == IDLE) begin
            gnt_c   = rr_gnt;
            sel_idx = rr_idx;
            sel_any = rr_any;
        end else if (req[owner_q]) begin
            gnt_c   = owner_oh;
            sel_idx = owner_q;
            sel_any = 1'b1;
        end
    end

    assign sel_addr  = addr[int'(sel_idx)*AW +: AW];
    assign sel_wdata = wdata[int'(sel_idx)*DATA_W +: DATA_W];
    assign sel_we    = we[sel_idx];
    assign sel_lock  = lock[sel_idx];

    // Lock FSM and round-robin pointer update.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_any) begin
                    ptr_d = next_idx(sel_idx);
                    if (sel_lock) begin
                        state_d = LOCKED;
                        owner_d = sel_idx;
                        cnt_d   = '0;
                    end
                end
            end
            LOCKED: begin
                if (req[owner_q]) begin
                    cnt_d = '0;
                    if (!lock[owner_q]) begin
                        state_d = IDLE;
                        ptr_d   = next_idx(owner_q);
                    end
                end else if (cnt_q == CW'(LOCK_TMO - 1)) begin
                    // Owner went quiet too long: drop the lock so others can proceed.
                    state_d = IDLE;
                    ptr_d   = next_idx(owner_q);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bank storage and registered read response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                bank[k] <= '0;
            end
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= '0;
            if (sel_any) begin
                if (sel_we) begin
                    bank[sel_addr] <= sel_wdata;
                end else begin
                    rdata_q  <= bank[sel_addr];
                    rvalid_q <= gnt_c;
                end
            end
        end
    end

    assign gnt       = reset ? '0 : gnt_c;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign locked    = (state_q == LOCKED);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: reset, read/write, round-robin order,
// lock hand-off, lock timeout and reset during a lock.
module tb_reg_bank_arbiter;

    localparam int N  = 4;
    localparam int AW = 3;

    logic              clk;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      we;
    logic [N-1:0]      lock;
    logic [N*AW-1:0]   addr;
    logic [N*32-1:0]   wdata;
    logic [N-1:0]      gnt;
    logic [N-1:0]      rvalid;
    logic [31:0]       rdata;
    logic              locked;
    logic              state_dbg;

    int n_checks;
    int n_pass;

    reg_bank_arbiter #(.N(N), .AW(AW), .LOCK_TMO(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .lock      (lock),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .locked    (locked),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic idle_all();
        req  = '0;
        we   = '0;
        lock = '0;
    endtask

    task automatic drive(input int i, input logic w, input logic l,
                         input logic [2:0] a, input logic [31:0] d);
        req[i]            = 1'b1;
        we[i]             = w;
        lock[i]           = l;
        addr[i*AW +: AW]  = a;
        wdata[i*32 +: 32] = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Checker
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    logic [N-1:0] e_oh;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset    = 1'b1;
        addr     = '0;
        wdata    = '0;
        idle_all();
        #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        #12 reset = 1'b0;

        // 1: every address reads zero after reset, latency one cycle
        for (int a = 0; a < 8; a++) begin
            idle_all();
            drive(0, 1'b0, 1'b0, 3'(a), 32'h0);
            settle();
            check("t1_gnt", 32'(gnt), 32'h1);
            tick();
            check("t1_rvalid", 32'(rvalid), 32'h1);
            check("t1_rdata", rdata, 32'h0);
        end
        idle_all();
        tick();
        check("t1_rvalid_drop", 32'(rvalid), 32'h0);

        // 2: write then read-after-write from another requester
        drive(0, 1'b1, 1'b0, 3'd2, 32'hDEADBEEF);
        settle();
        check("t2_wr_gnt", 32'(gnt), 32'h1);
        tick();
        check("t2_wr_no_rvalid", 32'(rvalid), 32'h0);
        idle_all();
        drive(1, 1'b0, 1'b0, 3'd2, 32'h0);
        settle();
        check("t2_rd_gnt", 32'(gnt), 32'h2);
        tick();
        check("t2_rvalid", 32'(rvalid), 32'h2);
        check("t2_rdata", rdata, 32'hDEADBEEF);
        idle_all();
        tick();
        check("t2_rvalid_drop", 32'(rvalid), 32'h0);
        check("t2_rdata_hold", rdata, 32'hDEADBEEF);

        // 3: pointer back to 0 via a grant to req3, then all four contend
        drive(3, 1'b0, 1'b0, 3'd0, 32'h0);
        settle();
        check("t3_pre_gnt", 32'(gnt), 32'h8);
        tick();
        for (int k = 0; k < 8; k++) begin
            idle_all();
            for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 3'd2, 32'h0);
            settle();
            e_oh = 4'b0001 << (k % 4);
            check("t3_gnt", 32'(gnt), 32'(e_oh));
            check("t3_onehot", 32'($countones(gnt)), 32'd1);
            tick();
            check("t3_rvalid", 32'(rvalid), 32'(e_oh));
            check("t3_rdata", rdata, 32'hDEADBEEF);
        end

        // 4: atomic RMW by req2 while req0/req1 keep asking
        idle_all();
        drive(1, 1'b0, 1'b0, 3'd0, 32'h0);
        settle();
        check("t4_pre_gnt", 32'(gnt), 32'h2);
        tick();
        idle_all();
        drive(0, 1'b0, 1'b0, 3'd0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'h0);
        drive(2, 1'b0, 1'b1, 3'd5, 32'h0);
        settle();
        check("t4_rd_gnt", 32'(gnt), 32'h4);
        tick();
        check("t4_locked", 32'(locked), 32'h1);
        check("t4_state_dbg", 32'(state_dbg), 32'h1);
        check("t4_rvalid", 32'(rvalid), 32'h4);
        check("t4_rdata", rdata, 32'h0);
        drive(2, 1'b1, 1'b0, 3'd5, 32'h12345678);
        settle();
        check("t4_wr_gnt", 32'(gnt), 32'h4);
        tick();
        check("t4_unlocked", 32'(locked), 32'h0);
        check("t4_wr_no_rvalid", 32'(rvalid), 32'h0);
        idle_all();
        for (int i = 0; i < N; i++) drive(i, 1'b0, 1'b0, 3'd5, 32'h0);
        settle();
        check("t4_next_gnt", 32'(gnt), 32'h8);
        tick();
        check("t4_rb_rvalid", 32'(rvalid), 32'h8);
        check("t4_rb_rdata", rdata, 32'h12345678);

        // 5: lock timeout after 16 idle owner cycles
        idle_all();
        drive(1, 1'b0, 1'b1, 3'd0, 32'h0);
        settle();
        check("t5_lock_gnt", 32'(gnt), 32'h2);
        tick();
        check("t5_locked", 32'(locked), 32'h1);
        idle_all();
        drive(0, 1'b0, 1'b0, 3'd5, 32'h0);
        for (int c = 1; c <= 16; c++) begin
            settle();
            check("t5_wait_gnt", 32'(gnt), 32'h0);
            tick();
            check("t5_locked_c", 32'(locked), (c < 16) ? 32'h1 : 32'h0);
        end
        settle();
        check("t5_after_gnt", 32'(gnt), 32'h1);
        tick();
        check("t5_after_rvalid", 32'(rvalid), 32'h1);
        check("t5_after_rdata", rdata, 32'h12345678);

        // 6: asynchronous reset in the middle of a lock
        idle_all();
        drive(0, 1'b1, 1'b1, 3'd7, 32'hAAAA5555);
        settle();
        check("t6_lock_gnt", 32'(gnt), 32'h1);
        tick();
        check("t6_locked", 32'(locked), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_locked", 32'(locked), 32'h0);
        check("t6_rst_gnt", 32'(gnt), 32'h0);
        check("t6_rst_rvalid", 32'(rvalid), 32'h0);
        check("t6_rst_rdata", rdata, 32'h0);
        check("t6_rst_state", 32'(state_dbg), 32'h0);
        #3 reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idle_all();
            drive(0, 1'b0, 1'b0, (k == 0) ? 3'd7 : ((k == 1) ? 3'd2 : 3'd5), 32'h0);
            settle();
            check("t6_rd_gnt", 32'(gnt), 32'h1);
            tick();
            check("t6_rd_rvalid", 32'(rvalid), 32'h1);
            check("t6_rd_rdata", rdata, 32'h0);
        end
        idle_all();
        tick();

        // Final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
